repne_seq_wb: RTL and testbench
===============================

// Module: repne_seq_wb
// PURPOSE
//  Sequences REPNE CMPS micro-op pairs and HLT at the writeback stage.
//  - Tracks first/second CMPS uop ordering.
//  - Generates the pointer-save enable and the REPNE repeat/terminate decisions.
//  - Latches processor halt.
//  - Sits beside the WB operand-select, validate and flags logic; its outputs drive their enables.
// PARAMETERS
//  CNT_W   32  width of count operand (ECX image from WB_RESULT_C)
//  ITER_W  16  width of the optional iteration counter
// PORTS
//  CLK                        in   1       clock
//  RST                        in   1       reset, synchronous, active-high
//  WB_V                       in   1       WB stage holds a valid uop
//  WB_flush                   in   1       pipeline flush (branch/except)
//  CS_IS_CMPS_FIRST_UOP_ALL   in   1       uop is CMPS first half
//  CS_IS_CMPS_SECOND_UOP_ALL  in   1       uop is CMPS second half
//  CS_IS_HALT_WB              in   1       uop is HLT
//  WB_d2_repne_wb             in   1       instruction carries REPNE prefix
//  ZF                         in   1       current_flags[6] after this uop
//  WB_RESULT_C                in   CNT_W   decremented count
//  seq_save_ptr               out  1       load CMPS temp-pointer register
//  seq_repeat                 out  1       reload EIP to same instr (REPNE continues)
//  seq_terminate              out  1       REPNE finished; take WB_Final_EIP
//  seq_halt_all               out  1       sticky halt
//  seq_err                    out  1       sticky uop-ordering error
//  seq_state                  out  2       current state (debug)
//  seq_iter_cnt               out  ITER_W  REPNE iterations of current instr
// BEHAVIOUR
//  Reset: state=IDLE; seq_halt_all, seq_err, seq_iter_cnt = 0; comb outputs 0.
//  States: IDLE=0, WAIT2=1 (first uop done), REPEAT=2 (awaiting next first uop), HALT=3.
//  Comb outputs: same cycle as the qualifying uop in WB; registered state updates at next CLK.
//  Let v = WB_V & ~WB_flush; term = ZF | (WB_RESULT_C == 0).
//  Priority: RST > WB_flush > HLT > CMPS sequencing.
//  HALT transitions and outputs:
//  - Any state, v & HLT -> HALT; seq_halt_all=1 next cycle.
//  - HALT is left only by RST; flush does not clear it. All comb outputs 0 in HALT.
//  WB_flush (not in HALT) -> IDLE next cycle; comb outputs forced 0; seq_iter_cnt cleared.
//  IDLE:
//  - v & FIRST -> WAIT2, seq_save_ptr=1.
//  - v & SECOND -> seq_err=1, stay IDLE.
//  WAIT2:
//  - v & SECOND & ~repne -> IDLE.
//  - v & SECOND & repne & term -> IDLE, seq_terminate=1.
//  - v & SECOND & repne & ~term -> REPEAT, seq_repeat=1, seq_iter_cnt++.
//  - v & FIRST -> seq_err=1, seq_save_ptr=1 (re-capture), stay WAIT2.
//  - Other valid uop -> seq_err=1 -> IDLE.
//  REPEAT:
//  - v & FIRST -> WAIT2, seq_save_ptr=1.
//  - Other valid uop -> seq_err=1 -> IDLE.
//  ~v cycles (bubbles) hold state in every state.
//  Simultaneous FIRST & SECOND set: treated as SECOND, seq_err=1.
//  Count: WB_RESULT_C==0 compared at full CNT_W width (no wrap check).
//  seq_iter_cnt: saturates at all-ones; cleared on entry to IDLE.
// CONFIGURATION
//  REPNE_ITER_CNT_EN:
//  - defined: seq_iter_cnt counter as above.
//  - undefined: no counter flops; seq_iter_cnt tied to 0. FSM behaviour identical.
// STRUCTURE
//  Shared package wb_pkg: state encodings SEQ_IDLE/WAIT2/REPEAT/HALT, SEQ_STATE_W=2.
//  One sub-module: equal_to_zero (existing) for WB_RESULT_C zero detect.
//  State/sticky flops: reg with sync RST.
// TESTING
//  1. Non-REP CMPS: FIRST then SECOND, repne=0 -> save_ptr=1 cyc0, state IDLE after cyc1, terminate=0.
//  2. REPNE, C=3,2,1,0, ZF=0 -> repeat=1 x3, terminate=1 on 4th SECOND; iter_cnt reaches 3 then clears.
//  3. REPNE, C=5, ZF=1 on first SECOND -> terminate=1, repeat=0, state IDLE.
//  4. HLT while in WAIT2 -> halt_all=1 next cycle; flush and further uops leave it 1 until RST.
//  5. SECOND in IDLE, or FIRST twice -> seq_err=1 sticky; RST mid-WAIT2 -> all outputs 0, IDLE.
//  6. WB_flush in REPEAT with v=1 & FIRST -> no save_ptr; IDLE next cycle; bubbles hold state.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: sequencer state encoding and uop classification.
package wb_pkg;

  localparam int unsigned SEQ_STATE_W = 2;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned ITER_W_DEF  = 16;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_WAIT2  = 2'd1,
    SEQ_REPEAT = 2'd2,
    SEQ_HALT   = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    UOP_OTHER  = 2'd0,
    UOP_FIRST  = 2'd1,
    UOP_SECOND = 2'd2,
    UOP_HALT   = 2'd3
  } uop_kind_e;

  // HLT outranks CMPS; a uop flagged both FIRST and SECOND is handled as SECOND.
  function automatic uop_kind_e uop_class(input logic first, input logic second,
                                          input logic halt);
    uop_kind_e k;
    k = UOP_OTHER;
    if (halt) begin
      k = UOP_HALT;
    end else if (second) begin
      k = UOP_SECOND;
    end else if (first) begin
      k = UOP_FIRST;
    end
    return k;
  endfunction

endpackage

// File: rtl/repne_seq_wb_if.sv
// WB-stage uop inputs and sequencer outputs for repne_seq_wb.
interface repne_seq_wb_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ITER_W = 16
);

  logic                         WB_V;
  logic                         WB_flush;
  logic                         CS_IS_CMPS_FIRST_UOP_ALL;
  logic                         CS_IS_CMPS_SECOND_UOP_ALL;
  logic                         CS_IS_HALT_WB;
  logic                         WB_d2_repne_wb;
  logic                         ZF;
  logic [CNT_W-1:0]             WB_RESULT_C;

  logic                         seq_save_ptr;
  logic                         seq_repeat;
  logic                         seq_terminate;
  logic                         seq_halt_all;
  logic                         seq_err;
  logic [wb_pkg::SEQ_STATE_W-1:0] seq_state;
  logic [ITER_W-1:0]            seq_iter_cnt;

  modport master (
    output WB_V, WB_flush, CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL,
           CS_IS_HALT_WB, WB_d2_repne_wb, ZF, WB_RESULT_C,
    input  seq_save_ptr, seq_repeat, seq_terminate, seq_halt_all, seq_err,
           seq_state, seq_iter_cnt
  );

  modport slave (
    input  WB_V, WB_flush, CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL,
           CS_IS_HALT_WB, WB_d2_repne_wb, ZF, WB_RESULT_C,
    output seq_save_ptr, seq_repeat, seq_terminate, seq_halt_all, seq_err,
           seq_state, seq_iter_cnt
  );

endinterface

// File: rtl/equal_to_zero.sv
// Full-width zero detect.
module equal_to_zero #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  output logic         zero_o
);

  assign zero_o = (a_i == W'(0));

endmodule

// File: rtl/repne_seq_wb.sv
// REPNE CMPS / HLT sequencer at writeback.
// Optional iteration counter enabled by defining REPNE_ITER_CNT_EN.
module repne_seq_wb
  import wb_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  repne_seq_wb_if.slave bus
);

  seq_state_e state_q, state_d;
  logic       halt_q, halt_d;
  logic       err_q, err_d;
  logic       save_ptr_c, repeat_c, terminate_c;
  logic       v, cnt_zero, term, dual;
  uop_kind_e  kind;

  equal_to_zero #(.W(CNT_W)) u_cnt_zero (
    .a_i    (bus.WB_RESULT_C),
    .zero_o (cnt_zero)
  );

  assign v    = bus.WB_V & ~bus.WB_flush;
  assign term = bus.ZF | cnt_zero;
  assign dual = bus.CS_IS_CMPS_FIRST_UOP_ALL & bus.CS_IS_CMPS_SECOND_UOP_ALL;
  assign kind = uop_class(bus.CS_IS_CMPS_FIRST_UOP_ALL, bus.CS_IS_CMPS_SECOND_UOP_ALL,
                          bus.CS_IS_HALT_WB);

  // Next-state and same-cycle enables; reset, flush and HALT suppress every enable.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    save_ptr_c  = 1'b0;
    repeat_c    = 1'b0;
    terminate_c = 1'b0;
    if (RST || state_q == SEQ_HALT) begin
      state_d = state_q;
    end else if (bus.WB_flush) begin
      state_d = SEQ_IDLE;
    end else if (v) begin
      unique case (kind)
        UOP_HALT: state_d = SEQ_HALT;
        UOP_SECOND: begin
          if (dual) err_d = 1'b1;
          if (state_q == SEQ_WAIT2) begin
            if (!bus.WB_d2_repne_wb) begin
              state_d = SEQ_IDLE;
            end else if (term) begin
              state_d     = SEQ_IDLE;
              terminate_c = 1'b1;
            end else begin
              state_d  = SEQ_REPEAT;
              repeat_c = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = SEQ_IDLE;
          end
        end
        UOP_FIRST: begin
          // A repeated first half re-captures the pointer but is still an ordering error.
          save_ptr_c = 1'b1;
          state_d    = SEQ_WAIT2;
          if (state_q == SEQ_WAIT2) err_d = 1'b1;
        end
        default: begin
          if (state_q != SEQ_IDLE) begin
            err_d   = 1'b1;
            state_d = SEQ_IDLE;
          end
        end
      endcase
    end
    halt_d = halt_q | (state_d == SEQ_HALT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SEQ_IDLE;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

`ifdef REPNE_ITER_CNT_EN
  logic [ITER_W-1:0] iter_q, iter_d;

  // Saturating count of repeats; cleared whenever the sequencer lands in IDLE.
  always_comb begin
    iter_d = iter_q;
    if (state_d == SEQ_IDLE) begin
      iter_d = ITER_W'(0);
    end else if (repeat_c && iter_q != {ITER_W{1'b1}}) begin
      iter_d = iter_q + ITER_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      iter_q <= ITER_W'(0);
    end else begin
      iter_q <= iter_d;
    end
  end

  assign bus.seq_iter_cnt = iter_q;
`else
  assign bus.seq_iter_cnt = ITER_W'(0);
`endif

  assign bus.seq_save_ptr  = save_ptr_c;
  assign bus.seq_repeat    = repeat_c;
  assign bus.seq_terminate = terminate_c;
  assign bus.seq_halt_all  = halt_q;
  assign bus.seq_err       = err_q;
  assign bus.seq_state     = state_q;

endmodule

// File: tb/tb_repne_seq_wb.sv
// Bench for repne_seq_wb: directed vector table, then random uops against a behavioural model.
module tb_repne_seq_wb;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ITER_W = 16;
`ifdef REPNE_ITER_CNT_EN
  localparam bit ITER_ON = 1'b1;
`else
  localparam bit ITER_ON = 1'b0;
`endif

  typedef struct packed {
    logic        rst, v, flush, first, second, hlt, repne, zf;
    logic [31:0] c;
  } stim_t;

  typedef struct packed {
    logic        sp, rp, tm;
    logic [1:0]  st;
    logic        halt, err;
    logic [15:0] iter;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  repne_seq_wb_if #(.CNT_W(CNT_W), .ITER_W(ITER_W)) bus ();

  repne_seq_wb #(.CNT_W(CNT_W), .ITER_W(ITER_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: which half of a CMPS pair is outstanding, plus sticky flags.
  bit m_halted, m_mid, m_loop, m_err;
  int m_iter;
  bit n_halted, n_mid, n_loop, n_err;
  int n_iter;

  function automatic stim_t mk(input logic r, v, fl, f, sc, h, rn, z, input logic [31:0] c);
    stim_t s;
    s = '{rst: r, v: v, flush: fl, first: f, second: sc, hlt: h, repne: rn, zf: z, c: c};
    return s;
  endfunction

  function automatic vec_t row(input stim_t s, input logic sp, rp, tm, input logic [1:0] st,
                               input logic h, er, input logic [15:0] it);
    vec_t r;
    r.s = s;
    r.e = '{sp: sp, rp: rp, tm: tm, st: st, halt: h, err: er, iter: it & {16{ITER_ON}}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, " save_ptr"},  32'(a.sp),   32'(e.sp));
    chk({tag, " repeat"},    32'(a.rp),   32'(e.rp));
    chk({tag, " terminate"}, 32'(a.tm),   32'(e.tm));
    chk({tag, " state"},     32'(a.st),   32'(e.st));
    chk({tag, " halt_all"},  32'(a.halt), 32'(e.halt));
    chk({tag, " err"},       32'(a.err),  32'(e.err));
    chk({tag, " iter_cnt"},  32'(a.iter), 32'(e.iter));
  endtask

  task automatic drive(input stim_t s);
    rst                           = s.rst;
    bus.WB_V                      = s.v;
    bus.WB_flush                  = s.flush;
    bus.CS_IS_CMPS_FIRST_UOP_ALL  = s.first;
    bus.CS_IS_CMPS_SECOND_UOP_ALL = s.second;
    bus.CS_IS_HALT_WB             = s.hlt;
    bus.WB_d2_repne_wb            = s.repne;
    bus.ZF                        = s.zf;
    bus.WB_RESULT_C               = s.c;
  endtask

  // One clock: enables sampled mid-cycle, registered outputs sampled just after the edge.
  task automatic cycle(input stim_t s, output obs_t o);
    @(negedge clk);
    drive(s);
    #1;
    o.sp = bus.seq_save_ptr;
    o.rp = bus.seq_repeat;
    o.tm = bus.seq_terminate;
    @(posedge clk);
    #1;
    o.st   = bus.seq_state;
    o.halt = bus.seq_halt_all;
    o.err  = bus.seq_err;
    o.iter = bus.seq_iter_cnt;
  endtask

  task automatic model_eval(input stim_t s, output obs_t e);
    e = '0;
    n_halted = m_halted; n_mid = m_mid; n_loop = m_loop; n_err = m_err; n_iter = m_iter;
    if (s.rst) begin
      n_halted = 0; n_mid = 0; n_loop = 0; n_err = 0; n_iter = 0;
    end else if (m_halted) begin
      n_halted = 1;
    end else if (s.flush) begin
      n_mid = 0; n_loop = 0; n_iter = 0;
    end else if (s.v) begin
      if (s.hlt) begin
        n_halted = 1; n_mid = 0; n_loop = 0;
      end else if (s.second) begin
        if (s.first || !m_mid) n_err = 1;
        n_mid = 0; n_loop = 0;
        if (m_mid && s.repne && !(s.zf || s.c == 0)) begin
          e.rp = 1; n_loop = 1;
          n_iter = (m_iter >= 65535) ? 65535 : m_iter + 1;
        end else begin
          e.tm = m_mid && s.repne;
          n_iter = 0;
        end
      end else if (s.first) begin
        e.sp = 1;
        if (m_mid) n_err = 1;
        n_mid = 1; n_loop = 0;
      end else if (m_mid || m_loop) begin
        n_err = 1; n_mid = 0; n_loop = 0; n_iter = 0;
      end
    end
    e.st   = n_halted ? 2'd3 : (n_mid ? 2'd1 : (n_loop ? 2'd2 : 2'd0));
    e.halt = n_halted;
    e.err  = n_err;
    e.iter = 16'(n_iter) & {16{ITER_ON}};
  endtask

  task automatic model_commit();
    m_halted = n_halted; m_mid = n_mid; m_loop = n_loop; m_err = n_err; m_iter = n_iter;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int    k, cs;
    s = '0;
    s.rst    = ($urandom_range(0, 31) == 0);
    s.v      = ($urandom_range(0, 3) != 0);
    s.flush  = ($urandom_range(0, 15) == 0);
    s.hlt    = ($urandom_range(0, 99) == 0);
    s.repne  = ($urandom_range(0, 3) != 0);
    s.zf     = ($urandom_range(0, 4) == 0);
    k        = int'($urandom_range(0, 99));
    s.first  = (k < 45) || (k >= 88 && k < 92);
    s.second = (k >= 45 && k < 92);
    cs       = int'($urandom_range(0, 3));
    s.c      = (cs == 0) ? 32'd0 : (cs == 1) ? 32'($urandom_range(1, 3)) :
               (cs == 2) ? (32'd1 << $urandom_range(16, 31)) : 32'($urandom);
    return s;
  endfunction

  initial begin
    vec_t tbl[$];
    obs_t o, e;
    stim_t s;
    stim_t R;

    R = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    m_halted = 0; m_mid = 0; m_loop = 0; m_err = 0; m_iter = 0;
    drive(R);
    repeat (2) @(posedge clk);
    #1;
    e = '0;
    o = '{sp: bus.seq_save_ptr, rp: bus.seq_repeat, tm: bus.seq_terminate, st: bus.seq_state,
          halt: bus.seq_halt_all, err: bus.seq_err, iter: bus.seq_iter_cnt};
    check_obs("reset", o, e);

    //                r v f F S H rn z  C                sp rp tm st h e it
    tbl.push_back(row(mk(0,1,0,1,0,0,0,0,32'd7),           1, 0, 0, 1, 0,0,0)); // plain CMPS
    tbl.push_back(row(mk(0,1,0,0,1,0,0,0,32'd7),           0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd6),           1, 0, 0, 1, 0,0,0)); // ZF ends REPNE
    tbl.push_back(row(mk(0,1,0,0,1,0,1,1,32'd5),           0, 0, 1, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd4),           1, 0, 0, 1, 0,0,0)); // count 3..0
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'd3),           0, 1, 0, 2, 0,0,1));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd3),           1, 0, 0, 1, 0,0,1));
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'd2),           0, 1, 0, 2, 0,0,2));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd2),           1, 0, 0, 1, 0,0,2));
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'd1),           0, 1, 0, 2, 0,0,3));
    tbl.push_back(row(mk(0,0,0,1,0,0,1,0,32'd1),           0, 0, 0, 2, 0,0,3)); // bubble
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd1),           1, 0, 0, 1, 0,0,3));
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'd0),           0, 0, 1, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd9),           1, 0, 0, 1, 0,0,0)); // flush in REPEAT
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'd9),           0, 1, 0, 2, 0,0,1));
    tbl.push_back(row(mk(0,1,1,1,0,0,1,0,32'd9),           0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,0,0,0,0,0,0,0,32'd0),           0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd1),           1, 0, 0, 1, 0,0,0)); // high-bit count
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'h0001_0000),   0, 1, 0, 2, 0,0,1));
    tbl.push_back(row(mk(0,1,0,0,0,0,1,0,32'd0),           0, 0, 0, 0, 0,1,0)); // stray uop
    tbl.push_back(row(R,                                   0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,0,1,0,1,0,32'd0),           0, 0, 0, 0, 0,1,0)); // SECOND in IDLE
    tbl.push_back(row(R,                                   0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,0,0,32'd0),           1, 0, 0, 1, 0,0,0)); // FIRST twice
    tbl.push_back(row(mk(0,1,0,1,0,0,0,0,32'd0),           1, 0, 0, 1, 0,1,0));
    tbl.push_back(row(mk(1,1,0,1,0,0,0,0,32'd0),           0, 0, 0, 0, 0,0,0)); // RST in WAIT2
    tbl.push_back(row(mk(0,1,0,1,1,0,1,0,32'd2),           0, 0, 0, 0, 0,1,0)); // dual in IDLE
    tbl.push_back(row(R,                                   0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd4),           1, 0, 0, 1, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,1,0,1,0,32'd4),           0, 1, 0, 2, 0,1,1)); // dual in WAIT2
    tbl.push_back(row(R,                                   0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,0,0,32'd0),           1, 0, 0, 1, 0,0,0)); // HLT in WAIT2
    tbl.push_back(row(mk(0,1,0,0,0,1,0,0,32'd0),           0, 0, 0, 3, 1,0,0));
    tbl.push_back(row(mk(0,1,1,0,0,0,0,0,32'd0),           0, 0, 0, 3, 1,0,0));
    tbl.push_back(row(mk(0,1,0,1,0,0,1,0,32'd3),           0, 0, 0, 3, 1,0,0));
    tbl.push_back(row(R,                                   0, 0, 0, 0, 0,0,0));
    tbl.push_back(row(mk(0,1,1,0,0,1,0,0,32'd0),           0, 0, 0, 0, 0,0,0)); // flushed HLT
    tbl.push_back(row(mk(0,1,0,1,0,1,0,0,32'd0),           0, 0, 0, 3, 1,0,0)); // HLT beats FIRST
    tbl.push_back(row(R,                                   0, 0, 0, 0, 0,0,0));

    foreach (tbl[i]) begin
      model_eval(tbl[i].s, e);
      cycle(tbl[i].s, o);
      model_commit();
      check_obs($sformatf("vec%0d", i), o, tbl[i].e);
    end

    for (int n = 0; n < 3000; n++) begin
      s = (n == 0) ? R : rand_stim();
      model_eval(s, e);
      cycle(s, o);
      model_commit();
      check_obs($sformatf("rand%0d", n), o, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
